// File: rtl/sram_resp_ram.sv
// Single-port responder for the core's SRAM-style port: 1-cycle registered reads, byte-enable
// write-first writes, sticky out-of-window error. Optional counters under SRAM_RESP_STATS_EN.
module sram_resp_ram #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        sram_err,
   output logic [31:0] sram_err_addr
`ifdef SRAM_RESP_STATS_EN
   ,
   output logic [31:0] sram_rd_cnt,
   output logic [31:0] sram_wr_cnt
`endif
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;
   // Window size in bytes computed wide so a 4 GiB window does not overflow the mask.
   localparam logic [33:0] WinBytes = 34'd1 << (ADDR_WIDTH + 2);
   localparam logic [31:0] WinMask  = ~(WinBytes[31:0] - 32'd1);

   logic [31:0]           mem_q [Depth];
   logic [ADDR_WIDTH-1:0] idx;
   logic                  hit;
   logic                  rd_hit;
   logic                  wr_hit;
   logic                  miss;
   logic [31:0]           old_word;
   logic [31:0]           merged_word;

   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;

   assign idx      = sram_addr[ADDR_WIDTH+1:2];
   assign hit      = (sram_addr & WinMask) == BASE_ADDR;
   assign rd_hit   = sram_en && hit && (sram_wen == 4'b0000);
   assign wr_hit   = sram_en && hit && (sram_wen != 4'b0000);
   assign miss     = sram_en && !hit;
   assign old_word = mem_q[idx];

   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (sram_wen[i]) begin
            merged_word[8*i +: 8] = sram_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      rdata_d    = rdata_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (sram_en) begin
         rdata_d = hit ? merged_word : 32'd0;
      end
      // Only the first miss after reset is logged.
      if (miss && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = sram_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
         err_addr_q <= 32'd0;
      end else begin
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Array has no reset; a write on an edge with reset high is suppressed.
   always_ff @(posedge clk) begin
      if (wr_hit && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (sram_wen[i]) begin
               mem_q[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
         end
      end
   end

   assign sram_rdata    = rdata_q;
   assign sram_err      = err_q;
   assign sram_err_addr = err_addr_q;

`ifdef SRAM_RESP_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rd_hit) rd_cnt_d = rd_cnt_q + 32'd1;
      if (wr_hit) wr_cnt_d = wr_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign sram_rd_cnt = rd_cnt_q;
   assign sram_wr_cnt = wr_cnt_q;
`else
   logic unused_rd_hit;
   assign unused_rd_hit = rd_hit;
`endif

endmodule

// File: tb/tb_sram_resp_ram.sv
// Randomized self-checking bench for sram_resp_ram against an array-based reference model.
module tb_sram_resp_ram;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 2 ** AW;
   localparam logic [31:0] BASE  = 32'h1FC0_0000;
   localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

   logic        clk = 1'b0;
   logic        reset;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_err;
   logic [31:0] sram_err_addr;
`ifdef SRAM_RESP_STATS_EN
   logic [31:0] sram_rd_cnt;
   logic [31:0] sram_wr_cnt;
`endif

   sram_resp_ram #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sram_en       (sram_en),
      .sram_wen      (sram_wen),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .sram_err      (sram_err),
      .sram_err_addr (sram_err_addr)
`ifdef SRAM_RESP_STATS_EN
      ,
      .sram_rd_cnt   (sram_rd_cnt),
      .sram_wr_cnt   (sram_wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mm    [DEPTH];
   bit          known [DEPTH];
   logic [31:0] exp_rdata;
   bit          exp_known;
   bit          exp_err;
   logic [31:0] exp_err_addr;
   logic [31:0] exp_rd_cnt;
   logic [31:0] exp_wr_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_rdata    = 32'd0;
      exp_known    = 1'b1;
      exp_err      = 1'b0;
      exp_err_addr = 32'd0;
      exp_rd_cnt   = 32'd0;
      exp_wr_cnt   = 32'd0;
   endtask

   task automatic model_step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata);
      int i;
      if (!en) return;
      if ((addr / WIN_BYTES) * WIN_BYTES == BASE) begin
         i = int'((addr - BASE) / 4);
         if (wen == 4'b0000) begin
            exp_rd_cnt = exp_rd_cnt + 32'd1;
         end else begin
            for (int b = 0; b < 4; b++)
               if (wen[b]) mm[i][8*b +: 8] = wdata[8*b +: 8];
            if (wen == 4'hF) known[i] = 1'b1;
            exp_wr_cnt = exp_wr_cnt + 32'd1;
         end
         exp_rdata = mm[i];
         exp_known = known[i];
      end else begin
         exp_rdata = 32'd0;
         exp_known = 1'b1;
         if (!exp_err) begin
            exp_err      = 1'b1;
            exp_err_addr = addr;
         end
      end
   endtask

   task automatic check_outputs();
      if (exp_known) check_eq("rdata", sram_rdata, exp_rdata);
      check_eq("err", 32'(sram_err), 32'(exp_err));
      check_eq("err_addr", sram_err_addr, exp_err_addr);
`ifdef SRAM_RESP_STATS_EN
      check_eq("rd_cnt", sram_rd_cnt, exp_rd_cnt);
      check_eq("wr_cnt", sram_wr_cnt, exp_wr_cnt);
`endif
   endtask

   task automatic do_req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
      @(negedge clk);
      sram_en    = en;
      sram_wen   = wen;
      sram_addr  = addr;
      sram_wdata = wdata;
      @(posedge clk);
      model_step(en, wen, addr, wdata);
      #1;
      check_outputs();
      sram_en = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) begin
         mm[i]    = 32'd0;
         known[i] = 1'b0;
      end
      reset      = 1'b1;
      sram_en    = 1'b0;
      sram_wen   = 4'h0;
      sram_addr  = 32'd0;
      sram_wdata = 32'd0;
      model_reset();
      #1;
      check_eq("reset_rdata", sram_rdata, 32'd0);
      check_eq("reset_err", 32'(sram_err), 32'd0);
      check_eq("reset_err_addr", sram_err_addr, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Full write then read, write-first response
      do_req(1'b1, 4'hF, 32'h1FC0_0010, 32'hDEAD_BEEF);
      check_eq("wr_resp", sram_rdata, 32'hDEAD_BEEF);
      do_req(1'b1, 4'h0, 32'h1FC0_0010, 32'h0);
      check_eq("rd_full", sram_rdata, 32'hDEAD_BEEF);

      // Byte enables
      do_req(1'b1, 4'b0101, 32'h1FC0_0010, 32'h1122_3344);
      do_req(1'b1, 4'h0, 32'h1FC0_0013, 32'h0);
      check_eq("rd_bytes", sram_rdata, 32'hDE22_BE44);

      // Back-to-back reads and idle hold
      for (int i = 0; i < 3; i++) do_req(1'b1, 4'hF, BASE + 32'(4 * i), 32'(i + 1));
      for (int i = 0; i < 3; i++) begin
         do_req(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
         check_eq("b2b_rd", sram_rdata, 32'(i + 1));
      end
      do_req(1'b0, 4'h0, BASE, 32'h0);
      check_eq("idle_hold", sram_rdata, 32'd3);

      // Misses: sticky flag, first address logged, array untouched
      do_req(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      check_eq("miss_rd_data", sram_rdata, 32'd0);
      do_req(1'b1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF);
      check_eq("miss_wr_data", sram_rdata, 32'd0);
      check_eq("miss_err", 32'(sram_err), 32'd1);
      check_eq("miss_err_addr", sram_err_addr, 32'h0000_0040);
      do_req(1'b1, 4'h0, 32'h1FC0_0010, 32'h0);
      check_eq("miss_no_write", sram_rdata, 32'hDE22_BE44);

      // Asynchronous reset mid-cycle; write during reset dropped
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("async_rst_rdata", sram_rdata, 32'd0);
      check_eq("async_rst_err", 32'(sram_err), 32'd0);
      check_eq("async_rst_err_addr", sram_err_addr, 32'd0);
`ifdef SRAM_RESP_STATS_EN
      check_eq("async_rst_rd_cnt", sram_rd_cnt, 32'd0);
      check_eq("async_rst_wr_cnt", sram_wr_cnt, 32'd0);
`endif
      @(negedge clk);
      sram_en    = 1'b1;
      sram_wen   = 4'hF;
      sram_addr  = 32'h1FC0_0010;
      sram_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      check_eq("rst_wr_rdata", sram_rdata, 32'd0);
      @(negedge clk);
      sram_en = 1'b0;
      reset   = 1'b0;

`ifdef SRAM_RESP_STATS_EN
      for (int i = 0; i < 5; i++) do_req(1'b1, 4'h0, BASE + 32'(4 * (i % 3)), 32'h0);
      for (int i = 0; i < 3; i++) do_req(1'b1, 4'h3, BASE + 32'h20, 32'(i));
      do_req(1'b1, 4'h0, 32'h0000_1000, 32'h0);
      do_req(1'b1, 4'hF, 32'h2000_0000, 32'h0);
      check_eq("stats_rd", sram_rd_cnt, 32'd5);
      check_eq("stats_wr", sram_wr_cnt, 32'd3);
      @(negedge clk);
      force dut.rd_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.rd_cnt_q;
      exp_rd_cnt = 32'hFFFF_FFFF;
      do_req(1'b1, 4'h0, BASE, 32'h0);
      check_eq("stats_wrap", sram_rd_cnt, 32'd0);
`endif

      do_req(1'b1, 4'h0, 32'h1FC0_0010, 32'h0);
      check_eq("rst_wr_dropped", sram_rdata, 32'hDE22_BE44);

      // Preload, then random traffic
      for (int i = 0; i < DEPTH; i++) do_req(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) < 8)
            a = BASE + (32'($urandom) & (WIN_BYTES - 32'd1));
         else
            a = $urandom;
         do_req(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) != 0) ? 4'(
                $urandom_range(0, 15)) : 4'h0, a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/sram_resp_ram.md
# sram_resp_ram

On-chip single-port memory that answers the CPU core's SRAM-style port (`*_sram_en/wen/addr/wdata/rdata`); it is the responder side of that port. One instance serves the instruction port and one the data port in simulation and SoC builds. Reads return data one cycle after the request. Byte-enable writes update the array in the request cycle. Out-of-window accesses are flagged and logged.

## Interface

Parameters:
- `ADDR_WIDTH`, default 16: word-address bits; depth is 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h1FC0_0000: window base; must be aligned to 4·2^ADDR_WIDTH.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `sram_en`, input, 1: request valid this cycle.
- `sram_wen`, input, 4: byte write enables; 4'b0000 means read.
- `sram_addr`, input, 32: byte address; bits [1:0] ignored.
- `sram_wdata`, input, 32: write data; byte i uses `sram_wdata[8i+7:8i]`.
- `sram_rdata`, output, 32: response word, registered.
- `sram_err`, output, 1: sticky out-of-window flag.
- `sram_err_addr`, output, 32: address of the first out-of-window access.
- `sram_rd_cnt`, output, 32: read counter. Present only with `SRAM_RESP_STATS_EN`.
- `sram_wr_cnt`, output, 32: write counter. Present only with `SRAM_RESP_STATS_EN`.

## Operation

- **Window check:** `hit = (sram_addr & ~(4·2^ADDR_WIDTH−1)) == BASE_ADDR`.
- **Word index:** `idx = sram_addr[ADDR_WIDTH+1:2]`.
- **Read** (`en=1`, `wen=0`, `hit=1`): `rdata <= mem[idx]` at the next edge.
- **Write** (`en=1`, `wen!=0`, `hit=1`):
  - Each byte with `wen[i]=1` is written.
  - `rdata <=` the merged post-write word (write-first), i.e. new bytes where `wen[i]=1` and old bytes elsewhere.
- **Miss** (`en=1`, `hit=0`):
  - No array write; `rdata <= 0`.
  - If `sram_err=0`: `sram_err <= 1` and `sram_err_addr <= sram_addr`.
  - Later misses leave `sram_err_addr` unchanged.
- **Idle** (`en=0`): `rdata` holds its last value; no state changes.
- **Back-to-back requests:** accepted every cycle with no stall.
  - A read immediately after a write to the same word returns the written data; no forwarding path is needed, because the array is written at the earlier edge.
- **Array contents:** not reset and undefined at power-up. No initialisation port.
- **Reset values:** `sram_rdata=0`, `sram_err=0`, `sram_err_addr=0`, `sram_rd_cnt=0`, `sram_wr_cnt=0`.
- **Reset mid-access:** any request in the reset cycle is dropped. A write with an edge coincident with `reset` high is not performed.

## Timing

- Read latency: exactly 1 cycle. The request is sampled at edge N and `sram_rdata` is valid after edge N; the core samples it at edge N+1.
- Write: the array is updated at edge N; the merged word is on `sram_rdata` after edge N.
- `sram_err` and `sram_err_addr` update at the edge that samples the miss.
- Counters update at the edge that samples the request.
- `reset` clears all registers immediately and asynchronously; release takes effect from the first edge with `reset=0`.
- No combinational path from any input to any output.

## Configuration

- Macro: `SRAM_RESP_STATS_EN`.
- **Defined:** `sram_rd_cnt` and `sram_wr_cnt` exist.
  - `rd_cnt` increments on each hit read.
  - `wr_cnt` increments on each hit write (any nonzero `wen`).
  - Misses count in neither.
  - Both wrap from 32'hFFFF_FFFF to 0.
- **Undefined:** both ports and both counters are absent. All other behaviour is identical.

## Test plan

- **Full write/read:** write 32'hDEADBEEF at 32'h1FC0_0010 with `wen=4'hF`, then read the same address. `rdata=32'hDEADBEEF` one cycle after the read; during the write response cycle `rdata` is also 32'hDEADBEEF.
- **Byte enables:** on top of the previous word, write 32'h1122_3344 with `wen=4'b0101`, then read. Result is 32'hDE22_BE44.
- **Back-to-back and idle:** three consecutive reads of indices 0, 1, 2 (preloaded 1, 2, 3) return 1, 2, 3 on three consecutive cycles. With `en=0` on the next cycle, `rdata` holds 3.
- **Miss:** read 32'h0000_0040, then write 32'h8000_0000. `rdata=0` after each; `sram_err=1`; `sram_err_addr=32'h0000_0040`. The array is unchanged, checked by rereading an earlier word.
- **Reset:** assert `reset` asynchronously mid-stream. `rdata`, `err` and counters go to 0 before the next edge. A write presented while `reset=1` is not stored.
- **Stats (with `SRAM_RESP_STATS_EN`):** 5 hit reads, 3 hit writes and 2 misses give `rd_cnt=5` and `wr_cnt=3`. A counter forced to 32'hFFFF_FFFF wraps to 0 after one more read.
